// File: rtl/blocking_channel_merge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blocking_channel_merge_if                                            |
// | Per-lane producer signals plus the single merged consumer port.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface blocking_channel_merge_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_BITS = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_is_full;
  logic [WIDTH-1:0]          out_data;
  logic [CH_BITS-1:0]        out_channel;
  logic                      out_valid;
  logic                      out_is_taken;

  modport slave (
    input  in_data, in_valid, out_is_taken,
    output in_is_full, out_data, out_channel, out_valid
  );

  modport master (
    output in_data, in_valid, out_is_taken,
    input  in_is_full, out_data, out_channel, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/blocking_channel_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blocking_channel_merge                                               |
// | Per-lane blocking FIFOs merged onto one tagged output by an arbiter. |
// | Option: BLOCKING_CHANNEL_MERGE_FIXED_PRIORITY_EN (lane 0 priority).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module blocking_channel_merge #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2,
  parameter int CHANNELS = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  blocking_channel_merge_if.slave bus
);
  localparam int CH_BITS  = $clog2(CHANNELS);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CHANNELS-1:0] nonempty_w;
  logic [CHANNELS-1:0] full_w;
  logic [CHANNELS-1:0] wr_en_w;
  logic [CHANNELS-1:0] pop_w;
  logic [WIDTH-1:0]    head_w [CHANNELS];

  logic                grant_valid_w;
  logic [CH_BITS-1:0]  grant_w;
  logic                pop_any_w;

  assign pop_any_w = bus.out_is_taken && grant_valid_w;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic [WIDTH-1:0]    mem_q [DEPTH];
      logic [PTR_BITS-1:0] wptr_q, wptr_d;
      logic [PTR_BITS-1:0] rptr_q, rptr_d;
      logic [CNT_BITS-1:0] count_q, count_d;

      // Full is decoded from the registered count, so a same-cycle pop never unblocks a write.
      assign full_w[i]     = (count_q == CNT_BITS'(DEPTH));
      assign nonempty_w[i] = (count_q != '0);
      assign wr_en_w[i]    = bus.in_valid[i] && !full_w[i];
      assign pop_w[i]      = pop_any_w && (grant_w == CH_BITS'(i));
      assign head_w[i]     = mem_q[rptr_q];

      always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en_w[i]) begin
          wptr_d = (wptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : wptr_q + PTR_BITS'(1);
        end
        if (pop_w[i]) begin
          rptr_d = (rptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : rptr_q + PTR_BITS'(1);
        end
        case ({wr_en_w[i], pop_w[i]})
          2'b10:   count_d = count_q + CNT_BITS'(1);
          2'b01:   count_d = count_q - CNT_BITS'(1);
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          count_q <= '0;
          for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= '0;
          end
        end else begin
          wptr_q  <= wptr_d;
          rptr_q  <= rptr_d;
          count_q <= count_d;
          if (wr_en_w[i]) begin
            mem_q[wptr_q] <= bus.in_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  endgenerate

`ifdef BLOCKING_CHANNEL_MERGE_FIXED_PRIORITY_EN
  // Descending scan so the lowest-index non-empty lane is the last to assign.
  always_comb begin
    grant_valid_w = 1'b0;
    grant_w       = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (nonempty_w[k]) begin
        grant_valid_w = 1'b1;
        grant_w       = CH_BITS'(k);
      end
    end
  end
`else
  logic [CH_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_BITS:0]   idx_w;
  logic [CH_BITS:0]   grant_inc_w;

  // Descending scan over offsets from rr_ptr: the smallest offset hit wins.
  always_comb begin
    grant_valid_w = 1'b0;
    grant_w       = '0;
    idx_w         = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr_q} + (CH_BITS+1)'(k);
      if (idx_w >= (CH_BITS+1)'(CHANNELS)) begin
        idx_w = idx_w - (CH_BITS+1)'(CHANNELS);
      end
      if (nonempty_w[idx_w[CH_BITS-1:0]]) begin
        grant_valid_w = 1'b1;
        grant_w       = idx_w[CH_BITS-1:0];
      end
    end
  end

  always_comb begin
    grant_inc_w = {1'b0, grant_w} + (CH_BITS+1)'(1);
    rr_ptr_d    = rr_ptr_q;
    if (pop_any_w) begin
      rr_ptr_d = (grant_inc_w >= (CH_BITS+1)'(CHANNELS)) ? '0 : grant_inc_w[CH_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bus.in_is_full  = full_w;
  assign bus.out_valid   = grant_valid_w;
  assign bus.out_data    = grant_valid_w ? head_w[grant_w] : '0;
  assign bus.out_channel = grant_valid_w ? grant_w : '0;

endmodule
`default_nettype wire
